// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Widths, FSM state encodings and the PC step.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // Word alignment test for a fetch target.
  function automatic logic is_aligned(
    input logic [XLEN-1:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: enabled register with
// asynchronous active-high reset to RESET_PC.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // Load a new PC only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RESET_PC;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM with
// redirect, discard of stale data and fault state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);

  logic [1:0]      state, state_d;
  logic            discard, discard_d;
  logic            flt_pend, flt_pend_d;
  logic [XLEN-1:0] tgt, tgt_d;
  logic [XLEN-1:0] pc, pc_d;
  logic            pc_en;
  logic            ld;
  logic            algn;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc)
  );

  assign algn        = is_aligned(redirect_pc);
  assign mem_req     = (state == S_REQ);
  assign instr_valid = (state == S_HOLD);
  assign fetch_fault = (state == S_FAULT);
  assign mem_addr    = pc;

  // Next-state, PC update and discard bookkeeping.
  always_comb begin
    state_d    = state;
    discard_d  = discard;
    flt_pend_d = flt_pend;
    tgt_d      = tgt;
    pc_en      = 1'b0;
    pc_d       = tgt;
    ld         = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid && !mem_ack) begin
          discard_d  = 1'b1;
          flt_pend_d = !algn;
          if (algn) tgt_d = redirect_pc;
        end else if (redirect_valid) begin
          discard_d  = 1'b0;
          flt_pend_d = 1'b0;
          if (algn) begin
            pc_en = 1'b1;
            pc_d  = redirect_pc;
          end else begin
            state_d = S_FAULT;
          end
        end else if (mem_ack) begin
          if (discard) begin
            discard_d  = 1'b0;
            flt_pend_d = 1'b0;
            if (flt_pend) begin
              state_d = S_FAULT;
            end else begin
              pc_en = 1'b1;
              pc_d  = tgt;
            end
          end else begin
            state_d = S_HOLD;
            ld      = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          if (algn) begin
            state_d = S_REQ;
            pc_en   = 1'b1;
            pc_d    = redirect_pc;
          end else begin
            state_d = S_FAULT;
          end
        end else if (instr_ready) begin
          state_d = S_REQ;
          pc_en   = 1'b1;
          pc_d    = pc + PC_INC;
        end
      end
      S_FAULT: begin
        if (redirect_valid && algn) begin
          state_d = S_REQ;
          pc_en   = 1'b1;
          pc_d    = redirect_pc;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM and discard/target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      discard  <= 1'b0;
      flt_pend <= 1'b0;
      tgt      <= RESET_PC;
    end else begin
      state    <= state_d;
      discard  <= discard_d;
      flt_pend <= flt_pend_d;
      tgt      <= tgt_d;
    end
  end

  // Capture the returned word and its address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (ld) begin
      instr    <= mem_rdata;
      instr_pc <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle
// vector table plus a transfer scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ack;
    logic        rdy;
    logic        e_req;
    logic        e_val;
    logic        e_flt;
    logic [31:0] e_addr;
    logic        push;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(
    input logic [31:0] a
  );
    return a ^ 32'h1357_9bdf;
  endfunction

  assign mem_rdata = dat(mem_addr);

  fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic vec_t mk(
    input logic rv, input logic [31:0] rpc,
    input logic ack, input logic rdy,
    input logic e_req, input logic e_val,
    input logic e_flt, input logic [31:0] e_addr,
    input logic push
  );
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ack = ack;
    v.rdy = rdy; v.e_req = e_req;
    v.e_val = e_val; v.e_flt = e_flt;
    v.e_addr = e_addr; v.push = push;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL xfer_unexp: got pc %h expected none",
                 instr_pc);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", instr_pc, e.pc);
        chk("xfer_instr", instr, e.ins);
      end
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.pc  = a;
    e.ins = dat(a);
    sb.push_back(e);
  endtask

  task automatic ctl(
    input string nm, input logic rq,
    input logic vl, input logic fl,
    input logic [31:0] ad
  );
    chk({nm, "_req"}, {31'b0, mem_req}, {31'b0, rq});
    chk({nm, "_val"}, {31'b0, instr_valid}, {31'b0, vl});
    chk({nm, "_flt"}, {31'b0, fetch_fault}, {31'b0, fl});
    chk({nm, "_addr"}, mem_addr, ad);
  endtask

  initial begin
    // rv rpc ack rdy | req val flt addr push
    tv.push_back(mk(0, 0, 1, 1, 1, 0, 0, 32'h100, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'h100, 0));
    tv.push_back(mk(0, 0, 1, 1, 1, 0, 0, 32'h104, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'h104, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h108, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h108, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h108, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'h108, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h10c, 0));
    tv.push_back(mk(1, 32'h400, 0, 0, 1, 0, 0, 32'h10c, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h10c, 0));
    tv.push_back(mk(1, 32'h80, 1, 0, 1, 0, 0, 32'h400, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h80, 1));
    tv.push_back(mk(1, 32'h200, 0, 1, 0, 1, 0, 32'h80, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h200, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h200, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h200, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h200, 1));
    tv.push_back(mk(1, 32'h402, 0, 1, 0, 1, 0, 32'h200, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0));
    tv.push_back(mk(1, 32'h403, 0, 0, 0, 0, 1, 32'h200, 0));
    tv.push_back(mk(1, 32'h500, 0, 0, 0, 0, 1, 32'h200, 0));
    tv.push_back(mk(1, 32'h7, 0, 0, 1, 0, 0, 32'h500, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h500, 0));
    tv.push_back(mk(1, 32'hffff_fffc, 0, 0, 0, 0, 1, 32'h500, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'hffff_fffc, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'hffff_fffc, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h0, 1));
    tv.push_back(mk(1, 32'h10, 0, 1, 0, 1, 0, 32'h0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h10, 0));
    tv.push_back(mk(1, 32'h300, 0, 0, 1, 0, 0, 32'h10, 0));
    tv.push_back(mk(1, 32'h400, 0, 0, 1, 0, 0, 32'h10, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h10, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 0, 0, 32'h400, 1));
    tv.push_back(mk(0, 0, 0, 1, 0, 1, 0, 32'h400, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 32'h404, 0));

    rst            = 1'b1;
    mem_ack        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    ctl("rst", 1, 0, 0, 32'h100);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      redirect_valid = tv[i].rv;
      redirect_pc    = tv[i].rpc;
      mem_ack        = tv[i].ack;
      instr_ready    = tv[i].rdy;
      @(negedge clk);
      ctl($sformatf("row%0d", i), tv[i].e_req,
          tv[i].e_val, tv[i].e_flt, tv[i].e_addr);
      mon();
      if (tv[i].push) push(tv[i].e_addr);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a pending request.
    redirect_valid = 1'b0;
    mem_ack        = 1'b0;
    instr_ready    = 1'b0;
    #2 rst = 1'b1;
    #1;
    ctl("arst", 1, 0, 0, 32'h100);
    chk("arst_instr", instr, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    ctl("late_ack", 1, 0, 0, 32'h100);
    mon();
    push(32'h100);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    ctl("hold", 0, 1, 0, 32'h100);
    chk("hold_instr", instr, dat(32'h100));
    chk("hold_ipc", instr_pc, 32'h100);
    mon();

    // Redirect in HOLD without ready drops the word.
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h600;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    ctl("drop", 1, 0, 0, 32'h600);
    mon();
    sb.delete();
    @(posedge clk);
    #1 mem_ack = 1'b1;
    @(negedge clk);
    push(32'h600);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    ctl("x600", 0, 1, 0, 32'h600);
    mon();
    @(posedge clk);
    #1 instr_ready = 1'b0;
    @(negedge clk);
    ctl("n604", 1, 0, 0, 32'h604);

    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
